// File: rtl/om_buf_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// om_pkg
// Shared definitions for the Oerder-Meyr sample buffer controller:
//   OM_BLK_AW  default log2 of the block length (samples per bank)
//   OM_RD_LAT  default buffer RAM read latency in cycles
//   r_state_t  read-side FSM state encoding (2 bits)
// ----------------------------------------------------------------------------
package om_pkg;

   localparam int OM_BLK_AW = 8;
   localparam int OM_RD_LAT = 1;

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_STREAM = 2'd1,
      R_DRAIN  = 2'd2,
      R_WAIT   = 2'd3
   } r_state_t;

endpackage

// File: rtl/om_buf_ctrl_if.sv
// ----------------------------------------------------------------------------
// om_buf_ctrl_if
// Bundles every non-clock signal of om_buf_ctrl.
//   master modport : the controller (drives RAM addresses, estimator framing,
//                    status flags, debug FSM state)
//   slave modport  : the surroundings (ADC stream, estimator, RAMs, status reader)
// Optional macro OM_BUF_CTRL_STATS_EN adds blk_cnt / drop_cnt.
//
// Handshakes: both streams are valid-only, no back-pressure. smp_valid marks
// one I/Q sample in the cycle it is high and cannot be stalled (a sample that
// meets a full bank is lost). est_valid marks that RAM dout_b holds a sample
// this cycle; est_sof/est_eof are only meaningful together with est_valid.
// est_done is a one-cycle pulse, honoured only while the read FSM waits.
// ----------------------------------------------------------------------------
interface om_buf_ctrl_if
   import om_pkg::*;
#(
   parameter int BLK_AW = OM_BLK_AW
) ();

   logic              smp_valid;
   logic              ram_we;
   logic [BLK_AW:0]   ram_waddr;
   logic [BLK_AW:0]   ram_raddr;
   logic              est_valid;
   logic              est_sof;
   logic              est_eof;
   logic              est_done;
   logic [1:0]        bank_full;
   logic              ovf;
   logic              ovf_clr;
   r_state_t          rd_state;
`ifdef OM_BUF_CTRL_STATS_EN
   logic [15:0]       blk_cnt;
   logic [15:0]       drop_cnt;
`endif

   modport master (
      input  smp_valid, est_done, ovf_clr,
      output ram_we, ram_waddr, ram_raddr, est_valid, est_sof, est_eof,
             bank_full, ovf, rd_state
`ifdef OM_BUF_CTRL_STATS_EN
      , output blk_cnt, drop_cnt
`endif
   );

   modport slave (
      output smp_valid, est_done, ovf_clr,
      input  ram_we, ram_waddr, ram_raddr, est_valid, est_sof, est_eof,
             bank_full, ovf, rd_state
`ifdef OM_BUF_CTRL_STATS_EN
      , input blk_cnt, drop_cnt
`endif
   );

endinterface

// File: rtl/om_buf_ctrl_lat_pipe.sv
// ----------------------------------------------------------------------------
// om_lat_pipe
// DEPTH-stage shift register that delays read-address side-band bits so they
// line up with the RAM read data.
//   clk, rst_n : clock, asynchronous active-low reset (clears all stages)
//   din[W]     : bits entering with the address
//   dout[W]    : same bits DEPTH cycles later (registered)
// ----------------------------------------------------------------------------
module om_lat_pipe #(
   parameter int DEPTH = 1,
   parameter int W     = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] sr [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/om_buf_ctrl.sv
// ----------------------------------------------------------------------------
// om_buf_ctrl
// Ping-pong scheduler for the shared I/Q buffer RAMs feeding the Oerder-Meyr
// timing estimator. The RAM address space is split into two banks by the
// address MSB. Incoming samples fill the free bank; a full bank is streamed
// to the estimator with sof/eof framing and held until est_done releases it.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    om_buf_ctrl_if.master:
//            smp_valid (in)  sample present, cannot stall
//            ram_we, ram_waddr (out)  port A write (I and Q RAMs together)
//            ram_raddr (out)          port B read address
//            est_valid/est_sof/est_eof (out) framing aligned to dout_b
//            est_done (in)   estimator finished current block
//            bank_full[1:0] (out)  per-bank occupancy
//            ovf (out) sticky overflow, ovf_clr (in) clears it
//            rd_state (out)  read FSM state for observation
//
// Parameters: BLK_AW (log2 block length), RD_LAT (RAM read latency, >= 1).
// Optional macro OM_BUF_CTRL_STATS_EN adds blk_cnt (releases) and drop_cnt
// (dropped samples, saturating); neither is affected by ovf_clr.
// ----------------------------------------------------------------------------
module om_buf_ctrl
   import om_pkg::*;
#(
   parameter int BLK_AW = OM_BLK_AW,
   parameter int RD_LAT = OM_RD_LAT
) (
   input  logic          clk,
   input  logic          rst_n,
   om_buf_ctrl_if.master bus
);

   localparam logic [BLK_AW-1:0] PTR_MAX    = '1;
   localparam int                DW         = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LAT - 1);

   logic              wbank;
   logic              rbank;
   logic [BLK_AW-1:0] wptr;
   logic [BLK_AW-1:0] rptr;
   logic [1:0]        bank_full;
   logic              ovf;
   r_state_t          rstate;
   logic [DW-1:0]     dcnt;

   logic              we;
   logic              drop;
   logic              fill;
   logic              rel;

   logic              addr_v;
   logic              addr_sof;
   logic              addr_eof;

   // Write side: the registered full flag gates the write, so a sample that
   // arrives in the same cycle its bank is being released is still dropped.
   assign we   = bus.smp_valid & ~bank_full[wbank];
   assign drop = bus.smp_valid &  bank_full[wbank];
   assign fill = we && (wptr == PTR_MAX);
   assign rel  = (rstate == R_WAIT) && bus.est_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr      <= '0;
         wbank     <= 1'b0;
         bank_full <= 2'b00;
         ovf       <= 1'b0;
      end else begin
         if (we) begin
            wptr <= wptr + 1'b1;
            if (wptr == PTR_MAX) wbank <= ~wbank;
         end
         // Release and fill always touch different banks: the writer never
         // writes into a full bank, and the reader only releases a full one.
         if (rel)  bank_full[rbank] <= 1'b0;
         if (fill) bank_full[wbank] <= 1'b1;
         if (drop)             ovf <= 1'b1;
         else if (bus.ovf_clr) ovf <= 1'b0;
      end
   end

   // Read FSM: stream one address per cycle, let the last read data leave the
   // RAM pipeline, then hold the bank until the estimator is done with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstate <= R_IDLE;
         rbank  <= 1'b0;
         rptr   <= '0;
         dcnt   <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (bank_full[rbank]) begin
                  rstate <= R_STREAM;
                  rptr   <= '0;
               end
            end
            R_STREAM: begin
               rptr <= rptr + 1'b1;
               if (rptr == PTR_MAX) begin
                  rstate <= R_DRAIN;
                  dcnt   <= '0;
               end
            end
            R_DRAIN: begin
               if (dcnt == DRAIN_LAST) rstate <= R_WAIT;
               else                    dcnt   <= dcnt + 1'b1;
            end
            R_WAIT: begin
               if (bus.est_done) begin
                  rbank  <= ~rbank;
                  rstate <= R_IDLE;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   assign addr_v   = (rstate == R_STREAM);
   assign addr_sof = addr_v && (rptr == '0);
   assign addr_eof = addr_v && (rptr == PTR_MAX);

   logic [2:0] pipe_out;

   om_lat_pipe #(
      .DEPTH (RD_LAT),
      .W     (3)
   ) u_lat_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({addr_v, addr_sof, addr_eof}),
      .dout  (pipe_out)
   );

   assign bus.ram_we    = we;
   assign bus.ram_waddr = {wbank, wptr};
   assign bus.ram_raddr = {rbank, rptr};
   assign bus.est_valid = pipe_out[2];
   assign bus.est_sof   = pipe_out[1];
   assign bus.est_eof   = pipe_out[0];
   assign bus.bank_full = bank_full;
   assign bus.ovf       = ovf;
   assign bus.rd_state  = rstate;

`ifdef OM_BUF_CTRL_STATS_EN
   logic [15:0] blk_cnt;
   logic [15:0] drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (rel) blk_cnt <= blk_cnt + 1'b1;
         if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign bus.blk_cnt  = blk_cnt;
   assign bus.drop_cnt = drop_cnt;
`endif

endmodule

// File: doc/om_buf_ctrl.md
Name: om_buf_ctrl

Overview:
Ping-pong scheduler for the shared I/Q sample buffers feeding the Oerder-Meyr timing estimator.
- Splits the dual-port buffer address space into two banks.
- Writes incoming I/Q samples into the free bank.
- Once a bank holds a full block, streams it on the read port to the estimator with framing strobes.
- Holds the bank until the estimator reports done, then releases it.
- Sits between the ADC sample stream, the two buffer RAMs (I and Q share addresses and write enable) and the estimator.

Parameters:
BLK_AW, 8, log2 of block length; block = 2^BLK_AW samples, RAM address width = BLK_AW+1 (MSB = bank).
RD_LAT, 1, RAM read latency in cycles (dout_b valid RD_LAT cycles after addr_b).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
smp_valid  in  1  one I/Q sample present this cycle (stream cannot stall)
ram_we  out  1  buffer write enable (both I and Q RAMs)
ram_waddr  out  BLK_AW+1  port A write address
ram_raddr  out  BLK_AW+1  port B read address
est_valid  out  1  RAM dout_b carries a valid sample for the estimator
est_sof  out  1  with est_valid: first sample of block
est_eof  out  1  with est_valid: last sample of block
est_done  in  1  single-cycle pulse from estimator: epsilon for current block produced
bank_full  out  2  per-bank occupancy flag
ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (async, rst_n=0): ram_we=0, ram_waddr=0, ram_raddr=0, est_valid/sof/eof=0, bank_full=00, ovf=0; write bank=0, read bank=0, read FSM=R_IDLE.
- Write side:
  - ram_we = smp_valid && !bank_full[wbank], combinational.
  - ram_waddr = {wbank, wptr}.
  - On each write, wptr increments.
  - At wptr = 2^BLK_AW-1: set bank_full[wbank], toggle wbank, wptr wraps to 0.
- Overflow:
  - smp_valid while bank_full[wbank]=1 drops the sample and sets ovf.
  - The write pointer does not advance.
  - Writing resumes automatically once the bank is released.
- ovf_clr clears ovf. If a drop occurs in the same cycle, set wins.
- Read FSM states:
  - R_IDLE: if bank_full[rbank], go to R_STREAM with rptr=0.
  - R_STREAM: issue ram_raddr={rbank,rptr}, one address per cycle, 2^BLK_AW cycles. After the last address, go to R_DRAIN.
  - R_DRAIN: wait RD_LAT cycles so the last data is flushed, then go to R_WAIT.
  - R_WAIT: on est_done, clear bank_full[rbank], toggle rbank, go to R_IDLE.
- Valid alignment:
  - Address-issue valid, sof (rptr=0) and eof (rptr=max) are delayed RD_LAT cycles through a shift pipe, then driven as est_valid/est_sof/est_eof.
  - These outputs are registered.
- est_done outside R_WAIT is ignored.
- Simultaneous events:
  - A release and a bank fill in the same cycle touch different banks, so both take effect.
  - A fill on rbank in the cycle R_WAIT releases it cannot happen, because the write side never writes a full bank.
  - If a release frees wbank while a sample arrives the same cycle, that sample is still dropped (uses the registered flag); the next sample is written.
- Block-to-block latency: R_IDLE→R_STREAM occurs on the cycle after bank_full rises.
- The read side always consumes banks in fill order (0,1,0,…).

Optional Feature:
Macro OM_BUF_CTRL_STATS_EN.
- Defined: adds outputs blk_cnt[15:0] and drop_cnt[15:0].
  - blk_cnt increments on each release.
  - drop_cnt increments on each dropped sample and saturates at 0xFFFF.
  - Both reset to 0 on rst_n.
  - Neither is cleared by ovf_clr.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package om_pkg holds:
  - OM_BLK_AW and OM_RD_LAT defaults.
  - Read FSM state enum (R_IDLE, R_STREAM, R_DRAIN, R_WAIT), 2-bit encoding.
- One natural sub-module: om_lat_pipe, a RD_LAT-deep shift register for {valid,sof,eof} with async active-low reset to 0.

Test Plan:
1. BLK_AW=3, RD_LAT=1, 8 consecutive smp_valid:
   - ram_waddr 0..7 written, bank_full=01.
   - Next cycle FSM enters R_STREAM.
   - ram_raddr 0..7; est_valid high 8 cycles, starting 1 cycle later.
   - est_sof on first, est_eof on eighth.
2. Continuous input for 16 samples with est_done withheld:
   - Bank 0 then bank 1 fill (waddr 8..15), bank_full=11.
   - 17th sample: ram_we=0 and ovf=1.
   - est_done pulse: bank_full=10, and the next sample writes address 0.
3. est_done pulsed during R_STREAM → ignored; FSM still waits in R_WAIT for a later pulse.
4. ovf=1, then ovf_clr in the same cycle as a further drop → ovf stays 1; ovf_clr alone next cycle → ovf=0.
5. Assert rst_n=0 mid R_STREAM (raddr=5) → all outputs 0 immediately and bank_full=00; after release, fresh block fills bank 0 from address 0.
6. With OM_BUF_CTRL_STATS_EN, 3 released blocks and 2 drops → blk_cnt=3, drop_cnt=2; ovf_clr leaves both unchanged.
